// File: rtl/raptor64_mult_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// raptor64_mult_ctrl_if: EX request, multiplier and writeback bus (rev 1.0)
// ----------------------------------------------------------------------------
interface raptor64_mult_ctrl_if #(
  parameter int TGTW = 6
);
  logic            req;
  logic            req_rdy;
  logic [2:0]      op;
  logic [63:0]     a;
  logic [63:0]     b;
  logic [63:0]     imm;
  logic [TGTW-1:0] tgt;
  logic            m_ld;
  logic            m_sgn;
  logic            m_isMuli;
  logic [63:0]     m_a;
  logic [63:0]     m_b;
  logic [63:0]     m_imm;
  logic [127:0]    m_o;
  logic            m_done;
  logic            res_vld;
  logic [63:0]     res;
  logic [TGTW-1:0] res_tgt;
  logic            res_ovf;
  logic            res_err;
  logic            res_ack;

  modport slave (
    input  req, op, a, b, imm, tgt, m_o, m_done, res_ack,
    output req_rdy, m_ld, m_sgn, m_isMuli, m_a, m_b, m_imm,
           res_vld, res, res_tgt, res_ovf, res_err
  );

  modport master (
    output req, op, a, b, imm, tgt, m_o, m_done, res_ack,
    input  req_rdy, m_ld, m_sgn, m_isMuli, m_a, m_b, m_imm,
           res_vld, res, res_tgt, res_ovf, res_err
  );
endinterface
`default_nettype wire

// File: rtl/raptor64_mult_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// raptor64_mult_ctrl: issue/writeback sequencer for Raptor64Mult (rev 1.0)
// ----------------------------------------------------------------------------
module raptor64_mult_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TGTW    = 6
) (
  input  wire logic           clk,
  input  wire logic           rst,
  raptor64_mult_ctrl_if.slave bus
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [63:0]     m_a_q, m_a_d, m_b_q, m_b_d, m_imm_q, m_imm_d;
  logic [TGTW-1:0] res_tgt_q, res_tgt_d;
  logic            m_sgn_q, m_sgn_d, m_is_muli_q, m_is_muli_d;
  logic            m_ld_q, m_ld_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [63:0]     res_q, res_d;
  logic            res_ovf_q, res_ovf_d, res_err_q, res_err_d;
  logic            req_rdy_q, req_rdy_d, res_vld_q, res_vld_d;

  logic [63:0]     prod_hi, prod_lo, prod_sel;
  logic            prod_ovf;

  // Ops 4/5 return the high half and never overflow; op[0] marks signed ops.
  always_comb begin
    prod_hi  = bus.m_o[127:64];
    prod_lo  = bus.m_o[63:0];
    prod_sel = op_q[2] ? prod_hi : prod_lo;
    prod_ovf = 1'b0;
    if (!op_q[2]) begin
      prod_ovf = op_q[0] ? (prod_hi != {64{prod_lo[63]}}) : (prod_hi != 64'd0);
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    m_a_d       = m_a_q;
    m_b_d       = m_b_q;
    m_imm_d     = m_imm_q;
    res_tgt_d   = res_tgt_q;
    m_sgn_d     = m_sgn_q;
    m_is_muli_d = m_is_muli_q;
    m_ld_d      = 1'b0;
    wd_d        = wd_q;
    res_d       = res_q;
    res_ovf_d   = res_ovf_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req && req_rdy_q) begin
          op_d        = bus.op;
          m_a_d       = bus.a;
          m_b_d       = bus.b;
          m_imm_d     = bus.imm;
          res_tgt_d   = bus.tgt;
          m_sgn_d     = bus.op[0];
          m_is_muli_d = !bus.op[2] && bus.op[1];
          wd_d        = '0;
          if (bus.op <= 3'd5) begin
            state_d = ST_LOAD;
            m_ld_d  = 1'b1;
          end else begin
            state_d   = ST_HOLD;
            res_d     = 64'd0;
            res_ovf_d = 1'b0;
            res_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the final watchdog cycle still completes normally.
        if (bus.m_done) begin
          state_d   = ST_HOLD;
          res_d     = prod_sel;
          res_ovf_d = prod_ovf;
          res_err_d = 1'b0;
        end else if (wd_q == WD_LAST) begin
          state_d   = ST_HOLD;
          res_d     = 64'd0;
          res_ovf_d = 1'b0;
          res_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.res_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_rdy_d = (state_d == ST_IDLE);
    res_vld_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      m_a_q       <= 64'd0;
      m_b_q       <= 64'd0;
      m_imm_q     <= 64'd0;
      res_tgt_q   <= '0;
      m_sgn_q     <= 1'b0;
      m_is_muli_q <= 1'b0;
      m_ld_q      <= 1'b0;
      wd_q        <= '0;
      res_q       <= 64'd0;
      res_ovf_q   <= 1'b0;
      res_err_q   <= 1'b0;
      req_rdy_q   <= 1'b1;
      res_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      m_a_q       <= m_a_d;
      m_b_q       <= m_b_d;
      m_imm_q     <= m_imm_d;
      res_tgt_q   <= res_tgt_d;
      m_sgn_q     <= m_sgn_d;
      m_is_muli_q <= m_is_muli_d;
      m_ld_q      <= m_ld_d;
      wd_q        <= wd_d;
      res_q       <= res_d;
      res_ovf_q   <= res_ovf_d;
      res_err_q   <= res_err_d;
      req_rdy_q   <= req_rdy_d;
      res_vld_q   <= res_vld_d;
    end
  end

  assign bus.req_rdy  = req_rdy_q;
  assign bus.m_ld     = m_ld_q;
  assign bus.m_sgn    = m_sgn_q;
  assign bus.m_isMuli = m_is_muli_q;
  assign bus.m_a      = m_a_q;
  assign bus.m_b      = m_b_q;
  assign bus.m_imm    = m_imm_q;
  assign bus.res_vld  = res_vld_q;
  assign bus.res      = res_q;
  assign bus.res_tgt  = res_tgt_q;
  assign bus.res_ovf  = res_ovf_q;
  assign bus.res_err  = res_err_q;
endmodule
`default_nettype wire
